// File: rtl/clkdiv_pkg.sv
// rtl/clkdiv_pkg.sv - shared types, defaults and ratio clamp for the multi-channel clock divider
`timescale 1ns/100ps
package clkdiv_pkg;

  localparam int DIV_W_DEF = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ch_state_t;

  // Ratios below 2 cannot produce both a high and a low phase, so they run as 2.
  function automatic logic [31:0] clamp2(input logic [31:0] d);
    return (d < 32'd2) ? 32'd2 : d;
  endfunction

endpackage

// File: rtl/clkdiv_ch.sv
// rtl/clkdiv_ch.sv - one divider channel: shadow ratio, active ratio, counter, RUN/IDLE FSM
// Optional CLKDIV_ODD50_EN adds a negedge flop giving 50% duty on odd ratios.
`timescale 1ns/100ps
module clkdiv_ch
  import clkdiv_pkg::*;
#(
  parameter int DIV_W   = DIV_W_DEF,
  parameter int DIV_RST = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync,
  input  logic             div_we,
  input  logic [DIV_W-1:0] div_wdata,
  output logic             clkout,
  output logic             tick,
  output logic             running
);

  localparam logic [DIV_W-1:0] ONE   = DIV_W'(1);
  localparam logic [DIV_W-1:0] D_RST = DIV_W'(clamp2(32'(DIV_RST)));

  ch_state_t        state;
  logic [DIV_W-1:0] shadow;
  logic [DIV_W-1:0] d_act;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] cnt_next;
  logic [DIV_W-1:0] high_cnt;
  logic             clk_q;
  logic             wrap;

  assign cnt_next = cnt + ONE;
  assign high_cnt = d_act >> 1;
  // A sync landing on a natural wrap is still just one wrap.
  assign wrap     = (state == IDLE) ? en : (sync || (cnt == d_act - ONE));

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      shadow <= DIV_W'(DIV_RST);
      d_act  <= D_RST;
      cnt    <= '0;
      state  <= IDLE;
      clk_q  <= 1'b0;
      tick   <= 1'b0;
    end else begin
      if (div_we) shadow <= div_wdata;
      if (wrap) begin
        d_act <= DIV_W'(clamp2(32'(shadow)));
        cnt   <= '0;
        state <= en ? RUN : IDLE;
        clk_q <= en;
        tick  <= en;
      end else begin
        tick <= 1'b0;
        if (state == RUN) begin
          cnt   <= cnt_next;
          clk_q <= (cnt_next < high_cnt);
        end
      end
    end
  end

  assign running = (state == RUN);

`ifdef CLKDIV_ODD50_EN
  logic neg_q;

  always_ff @(negedge clk or posedge rst_n) begin
    if (rst_n) neg_q <= 1'b0;
    else       neg_q <= clk_q;
  end

  // Half-cycle stretch of the high phase only matters for odd ratios.
  assign clkout = d_act[0] ? (clk_q | neg_q) : clk_q;
`else
  assign clkout = clk_q;
`endif

endmodule

// File: rtl/clkdiv_multi.sv
// rtl/clkdiv_multi.sv - N_CH programmable clock divider channels sharing one sync pulse
// Channels honour CLKDIV_ODD50_EN for odd-ratio 50% duty.
`timescale 1ns/100ps
module clkdiv_multi
  import clkdiv_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int DIV_W   = DIV_W_DEF,
  parameter int DIV_RST = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       en,
  input  logic                  sync,
  input  logic [N_CH-1:0]       div_we,
  input  logic [N_CH*DIV_W-1:0] div_wdata,
  output logic [N_CH-1:0]       clkout,
  output logic [N_CH-1:0]       tick,
  output logic [N_CH-1:0]       running
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    clkdiv_ch #(
      .DIV_W  (DIV_W),
      .DIV_RST(DIV_RST)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en[i]),
      .sync     (sync),
      .div_we   (div_we[i]),
      .div_wdata(div_wdata[i*DIV_W +: DIV_W]),
      .clkout   (clkout[i]),
      .tick     (tick[i]),
      .running  (running[i])
    );
  end

endmodule

// File: tb/tb_clkdiv_multi.sv
// tb/tb_clkdiv_multi.sv - scoreboard bench for clkdiv_multi (duty check follows CLKDIV_ODD50_EN)
`timescale 1ns/100ps
module tb_clkdiv_multi;

  localparam int N_CH  = 4;
  localparam int DIV_W = 8;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b1;
  logic [N_CH-1:0]       en = '0;
  logic                  sync = 1'b0;
  logic [N_CH-1:0]       div_we = '0;
  logic [N_CH*DIV_W-1:0] div_wdata = '0;
  logic [N_CH-1:0]       clkout;
  logic [N_CH-1:0]       tick;
  logic [N_CH-1:0]       running;

  clkdiv_multi #(.N_CH(N_CH), .DIV_W(DIV_W), .DIV_RST(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sync(sync), .div_we(div_we),
    .div_wdata(div_wdata), .clkout(clkout), .tick(tick), .running(running)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int ch;
    int cyc;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ticks(input int ch, input int first, input int per, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.ch  = ch;
      e.cyc = first + k * per;
      sb.push_back(e);
    end
  endtask

  task automatic wr(input int ch, input int v);
    div_wdata[ch*DIV_W +: DIV_W] = 8'(v);
    div_we[ch] = 1'b1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: every tick must match the oldest expectation for its channel.
  always @(negedge clk) begin
    int idx;
    for (int i = 0; i < N_CH; i++) begin
      if (tick[i]) begin
        idx = -1;
        for (int j = 0; j < sb.size(); j++) begin
          if (sb[j].ch == i) begin
            idx = j;
            break;
          end
        end
        if (idx < 0) chk($sformatf("tick_unexpected_ch%0d", i), cyc, -1);
        else begin
          chk($sformatf("tick_ch%0d", i), cyc, sb[idx].cyc);
          sb.delete(idx);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int b;
    int highs;
    repeat (3) @(negedge clk);
    chk("rst_clkout", int'(clkout), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_running", int'(running), 0);

    // All channels at reset ratio 2
    b = cyc;
    rst_n = 1'b0;
    en = 4'hf;
    for (int i = 0; i < N_CH; i++) push_ticks(i, b + 1, 2, 4);
    wait_cyc(b + 1); chk("t1_running", int'(running), 15); chk("t1_high", int'(clkout), 15);
    wait_cyc(b + 2); chk("t1_low", int'(clkout), 0);
    wait_cyc(b + 7); en = '0;
    wait_cyc(b + 9); chk("t1_stopped", int'(running), 0);

    // ch1: ratio 4, change to 5 mid-period, then write on a wrap cycle
    b = cyc;
    wr(1, 4);
    wait_cyc(b + 1); div_we = '0; en[1] = 1'b1;
    push_ticks(1, b + 2, 4, 2);
    push_ticks(1, b + 11, 5, 3);
    push_ticks(1, b + 25, 4, 1);
    wait_cyc(b + 3); wr(1, 5);
    wait_cyc(b + 4); div_we = '0;
    wait_cyc(b + 12); chk("t2_d5_high", int'(clkout[1]), 1);
    wait_cyc(b + 14); chk("t2_d5_low", int'(clkout[1]), 0);
    wait_cyc(b + 15); wr(1, 4);
    wait_cyc(b + 16); div_we = '0;
    wait_cyc(b + 25); en[1] = 1'b0;
    wait_cyc(b + 28); chk("t2_last_period", int'(running[1]), 1);
    wait_cyc(b + 29); chk("t2_stopped", int'(running[1]), 0);

    // ch2: ratios 0 and 1 behave as 2
    b = cyc;
    wr(2, 0);
    wait_cyc(b + 1); div_we = '0; en[2] = 1'b1;
    push_ticks(2, b + 2, 2, 4);
    wait_cyc(b + 2); chk("t3_d0_high", int'(clkout[2]), 1);
    wait_cyc(b + 3); chk("t3_d0_low", int'(clkout[2]), 0); wr(2, 1);
    wait_cyc(b + 4); div_we = '0;
    wait_cyc(b + 8); chk("t3_d1_high", int'(clkout[2]), 1); en[2] = 1'b0;
    wait_cyc(b + 9); chk("t3_d1_low", int'(clkout[2]), 0);
    wait_cyc(b + 10); chk("t3_stopped", int'(running[2]), 0);

    // ch0 ratio 3, ch3 ratio 7, sync realigns; then sync+wrap, then sync with en low
    b = cyc;
    wr(0, 3); wr(3, 7);
    wait_cyc(b + 1); div_we = '0; en = 4'b1001;
    push_ticks(0, b + 2, 3, 4);
    push_ticks(0, b + 12, 3, 8);
    push_ticks(3, b + 2, 7, 2);
    push_ticks(3, b + 12, 7, 4);
    wait_cyc(b + 11); sync = 1'b1;
    wait_cyc(b + 12); sync = 1'b0;
    wait_cyc(b + 14); chk("t4_d7_high", int'(clkout[3]), 1);
    wait_cyc(b + 16); chk("t4_d7_low", int'(clkout[3]), 0);
    wait_cyc(b + 32); sync = 1'b1;
    wait_cyc(b + 33); sync = 1'b0; en = '0;
    wait_cyc(b + 34); chk("t4_running_pre_sync", int'(running), 9); sync = 1'b1;
    wait_cyc(b + 35); sync = 1'b0; chk("t4_sync_stop", int'(running), 0);
    chk("t4_sync_stop_clk", int'(clkout), 0);

    // ch2 ratio 6, en dropped at cnt=1
    b = cyc;
    wr(2, 6);
    wait_cyc(b + 1); div_we = '0; en[2] = 1'b1;
    push_ticks(2, b + 2, 1, 1);
    wait_cyc(b + 3); en[2] = 1'b0;
    wait_cyc(b + 4); chk("t5_high3", int'(clkout[2]), 1);
    wait_cyc(b + 5); chk("t5_low", int'(clkout[2]), 0);
    wait_cyc(b + 7); chk("t5_still_run", int'(running[2]), 1);
    wait_cyc(b + 8); chk("t5_idle", int'(running[2]), 0);
    wait_cyc(b + 10); en[2] = 1'b1;
    push_ticks(2, b + 11, 1, 1);
    wait_cyc(b + 11); en[2] = 1'b0;
    wait_cyc(b + 17); chk("t5_idle2", int'(running[2]), 0);

    // Asynchronous reset mid-high
    b = cyc;
    en[2] = 1'b1;
    push_ticks(2, b + 1, 1, 1);
    wait_cyc(b + 1);
    @(posedge clk);
    #1 chk("t6_pre_rst_high", int'(clkout[2]), 1);
    #1 rst_n = 1'b1;
    #1 chk("t6_rst_clkout", int'(clkout[2]), 0);
    chk("t6_rst_running", int'(running), 0);
    en = '0;
    @(negedge clk); rst_n = 1'b0;

    // ch0 ratio 5 duty measured in time
    b = cyc;
    wr(0, 5);
    wait_cyc(b + 1); div_we = '0; en[0] = 1'b1;
    push_ticks(0, b + 2, 5, 2);
    @(posedge clk);
    #0.5;
    highs = 0;
    for (int k = 0; k < 50; k++) begin
      if (clkout[0]) highs++;
      #1;
    end
`ifdef CLKDIV_ODD50_EN
    chk("t7_d5_high_ns", highs, 25);
`else
    chk("t7_d5_high_ns", highs, 20);
`endif
    wait_cyc(b + 7); en[0] = 1'b0;
    wait_cyc(b + 12); chk("t7_stopped", int'(running), 0);

    wait_cyc(cyc + 4);
    chk("ticks_pending", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clkdiv_multi.md
Name: clkdiv_multi

Overview:
- Multi-channel programmable clock divider; parametrised successor to the single fixed-ratio divider.
- N_CH independent channels, each with a run-time divide ratio, glitch-free ratio change, enable/stop at period boundary, common phase re-sync and a per-channel period tick.
- Sits at the clock/timing utility level, feeding slow strobes and divided clocks to peripherals.

Parameters:
- N_CH, 4, number of divider channels.
- DIV_W, 8, width of each channel's divide ratio.
- DIV_RST, 2, reset value of every channel's shadow ratio register.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-high.
- en  in  N_CH  per-channel run enable.
- sync  in  1  one-cycle pulse; restarts all running channels in phase.
- div_we  in  N_CH  per-channel write strobe for the shadow ratio.
- div_wdata  in  N_CH*DIV_W  per-channel ratio; channel i at bits [i*DIV_W +: DIV_W].
- clkout  out  N_CH  divided clock outputs (registered).
- tick  out  N_CH  one-clk pulse coincident with each clkout rising edge.
- running  out  N_CH  channel is in RUN state.

Behaviour:
- Reset: shadow=DIV_RST, D_act=max(DIV_RST,2), cnt=0, state=IDLE, clkout=0, tick=0, running=0. Applies immediately, without waiting for clk. Reset mid-period drops clkout to 0 at once.
- Per channel: shadow register loads div_wdata slice on div_we, every cycle, in any state.
- D_act loads max(shadow,2) at every wrap event, so values 0 and 1 act as 2. A write in the same cycle as a wrap does not affect that wrap; it takes effect at the next wrap.
- High count H = D_act>>1. Period = D_act clk cycles, high for H cycles, low for D_act-H cycles.
- State IDLE: cnt=0, clkout=0.
  - en[i]=1 is a wrap event: next edge gives state=RUN, cnt=0, clkout=1, tick=1.
- State RUN: each edge cnt increments and clkout<=(cnt_next<H).
  - At cnt==D_act-1 the next edge is a wrap event.
  - Wrap with en[i]=1: cnt=0, clkout=1, tick=1, D_act reloaded.
  - Wrap with en[i]=0: state=IDLE, clkout stays 0, no tick. A stop is glitch-free; the current period always completes.
- sync=1 forces a wrap event on every RUN channel regardless of cnt.
  - All such channels show cnt=0, clkout=1, tick=1 on the same edge.
  - A channel with en low goes IDLE at once.
  - No effect on IDLE channels.
- Simultaneous sync and natural wrap: a single wrap, no double tick.
- running = (state==RUN). Minimum high and low pulse width is 1 clk cycle.

Optional Feature:
- Macro CLKDIV_ODD50_EN.
- Defined:
  - Each channel adds a negedge flop (async reset to 0) that samples the posedge clkout.
  - For odd D_act, clkout = posedge_q | negedge_q, giving exactly D_act/2 cycles high (50% duty).
  - For even D_act, the posedge_q path alone is output.
  - tick and running are unchanged.
- Undefined: no negedge logic; odd ratios are high floor(D/2) cycles.

Decomposition:
- Package clkdiv_pkg:
  - DIV_W default constant.
  - Channel state enum (IDLE, RUN).
  - Clamp function max(d,2).
- Sub-module clkdiv_ch holds one channel: shadow, D_act, cnt, FSM, optional negedge flop.
- clkdiv_multi instantiates N_CH clkdiv_ch via generate, fans out sync, and slices div_wdata.

Test Plan:
- Reset released, en=4'b1111, no writes -> every channel period 2 clks, high 1/low 1. First tick on the first edge after en is seen; running=1.
- ch1 running D=4, write 5 mid-period -> current period 4 clks, next periods 5 clks (high 2, low 3), one tick per period. Write on the wrap cycle -> still one more 4-clk period.
- Write 0, then 1, to ch2 -> after next wrap, period 2 clks, identical to D=2.
- ch0 D=3 and ch3 D=7 free-running, sync pulse mid-period -> both clkout rise and tick on the next edge. Thereafter, coincident ticks every 21 clks.
- ch2 D=6, en low at cnt=1 -> high 3/low 3 completes, then clkout=0, running=0, no ticks. en high again -> rise and tick on the next edge.
- rst_n pulsed between clk edges mid-high phase -> clkout=0 immediately. With CLKDIV_ODD50_EN at 100 MHz, D=5 -> clkout high 25 ns, low 25 ns.
